cheshire_reg_rr_arbiter: RTL

//  Shares the single external register-bus slave port of the SoC between NumReq register masters
//  (debug bridge, boot sequencer, host CPU shim, ...). Arbitrates round-robin, locks the grant

---
 rtl/cheshire_reg_arb_pkg.sv | 8 +
 rtl/reg_arb_rr_pick.sv | 24 ++
 rtl/cheshire_reg_rr_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/cheshire_reg_arb_pkg.sv
// cheshire_reg_arb_pkg: shared types and constants for the register-bus round-robin arbiter
package cheshire_reg_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam logic [31:0] RegArbTimeoutData = 32'hBADCAB1E;
  function automatic int unsigned rr_wrap(int unsigned i, int unsigned n);
    return i % n;
  endfunction
endpackage

// File: rtl/reg_arb_rr_pick.sv
// reg_arb_rr_pick: combinational round-robin pick, first valid index at or after the pointer
module reg_arb_rr_pick import cheshire_reg_arb_pkg::*; #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   valid,
  input  logic [IdxWidth-1:0] ptr,
  output logic [NumReq-1:0]   onehot,
  output logic [IdxWidth-1:0] idx,
  output logic                any
);
  logic [NumReq-1:0]   rot;
  logic [IdxWidth-1:0] first;
  always_comb begin
    rot   = '0;
    first = '0;
    for (int i = 0; i < NumReq; i++) rot[i] = valid[IdxWidth'(rr_wrap(i + 32'(ptr), NumReq))];
    // trailing-zero count of the rotated vector, i.e. distance from the pointer
    for (int i = NumReq - 1; i >= 0; i--) if (rot[i]) first = IdxWidth'(i);
    any    = |valid;
    idx    = IdxWidth'(rr_wrap(32'(first) + 32'(ptr), NumReq));
    onehot = any ? NumReq'(1) << idx : '0;
  end
endmodule

// File: rtl/cheshire_reg_rr_arbiter.sv
// cheshire_reg_rr_arbiter: round-robin sharing of one reg-bus slave port with grant lock and timeout
module cheshire_reg_rr_arbiter import cheshire_reg_arb_pkg::*; #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxWidth  = $clog2(NumReq),
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned CntWidth  = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_write_i,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
  input  logic [NumReq*StrbWidth-1:0]   req_wstrb_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [DataWidth-1:0]          req_rdata_o,
  output logic [NumReq-1:0]             req_error_o,
  output logic                          slv_valid_o,
  output logic                          slv_write_o,
  output logic [AddrWidth-1:0]          slv_addr_o,
  output logic [DataWidth-1:0]          slv_wdata_o,
  output logic [StrbWidth-1:0]          slv_wstrb_o,
  input  logic                          slv_ready_i,
  input  logic [DataWidth-1:0]          slv_rdata_i,
  input  logic                          slv_error_i,
  output logic [NumReq-1:0]             grant_o,
  output logic                          timeout_o
);
  localparam logic [DataWidth-1:0] TimeoutData = DataWidth'(RegArbTimeoutData);
  localparam logic [CntWidth-1:0]  CntMax      = CntWidth'(TimeoutCycles);
  localparam logic [CntWidth-1:0]  CntLast     = CntWidth'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);
  state_e              state;
  logic [IdxWidth-1:0] win, ptr, pick_idx, next_ptr;
  logic [NumReq-1:0]   win_oh, pick_oh;
  logic [CntWidth-1:0] cnt;
  logic                pick_any, busy, win_valid, tmo, done;
  reg_arb_rr_pick #(.NumReq(NumReq)) i_pick (
    .valid  (req_valid_i),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );
  always_comb begin
    busy        = state == BUSY;
    win_valid   = busy & req_valid_i[win];
    // a completion in the timeout cycle wins over the forced error
    tmo         = TimeoutCycles > 0 && win_valid && cnt == CntLast && !slv_ready_i;
    slv_valid_o = win_valid & ~tmo;
    done        = slv_valid_o & slv_ready_i;
    slv_write_o = busy & req_write_i[win];
    slv_addr_o  = busy ? req_addr_i[32'(win) * AddrWidth +: AddrWidth] : '0;
    slv_wdata_o = busy ? req_wdata_i[32'(win) * DataWidth +: DataWidth] : '0;
    slv_wstrb_o = busy ? req_wstrb_i[32'(win) * StrbWidth +: StrbWidth] : '0;
    req_ready_o = (done | tmo) ? win_oh : '0;
    req_error_o = (tmo | (done & slv_error_i)) ? win_oh : '0;
    req_rdata_o = !busy ? '0 : tmo ? TimeoutData : slv_rdata_i;
    timeout_o   = tmo;
    grant_o     = busy ? win_oh : '0;
    next_ptr    = IdxWidth'(rr_wrap(32'(win) + 1, NumReq));
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      win    <= '0;
      win_oh <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else if (!busy) begin
      if (pick_any) begin
        state  <= BUSY;
        win    <= pick_idx;
        win_oh <= pick_oh;
      end
      cnt <= '0;
    end else if (done | tmo | !win_valid) begin
      state <= IDLE;
      ptr   <= next_ptr;
      cnt   <= '0;
    end else if (cnt != CntMax) begin
      cnt <= cnt + CntWidth'(1);
    end
  end
endmodule
